sd_block_reader: RTL and testbench

Single-block SD read engine (CMD17, SPI mode) that runs after the card initialisation stage reports completion. It takes a block address and a one-cycle request, drives the SPI bus (CS, MOSI, spi_clk, MISO), and polls for R1 and the data start token. It then streams the 512 data bytes out as a byte/valid interface to the downstream consumer (FAT parser / buffer). Errors are reported per request with a code.

---
 rtl/sd_block_reader.sv | 236 +++++++++++++++++++++++
 tb/tb_sd_block_reader.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_reader.sv
// Single-block SD read engine (CMD17, SPI mode 0): streams 512 data bytes out on rd_data/rd_valid.
// Optional build macro SD_BLOCK_CRC16_EN checks the data CRC16 and reports a mismatch as err_code 5.
module sd_block_reader #(
    parameter int CLK_DIV       = 2,
    parameter int R1_TIMEOUT    = 8,
    parameter int TOKEN_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        sdhc,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        busy,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_done,
    output logic        rd_err,
    output logic [2:0]  err_code,
    output logic        CS,
    output logic        MOSI,
    output logic        spi_clk,
    input  logic        MISO,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CMD        = 3'd1,
        S_R1_POLL    = 3'd2,
        S_TOKEN_WAIT = 3'd3,
        S_DATA       = 3'd4,
        S_CRC        = 3'd5,
        S_END        = 3'd6
    } state_t;

    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [15:0] R1_LAST    = 16'(R1_TIMEOUT - 1);
    localparam logic [15:0] TOKEN_LAST = 16'(TOKEN_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [3:0]  half_cnt;
    logic [7:0]  tx_sr;
    logic [7:0]  rx_sr;
    logic [15:0] cnt;
    logic [8:0]  data_cnt;
    logic [31:0] arg;
    logic [2:0]  end_code;
    logic        tick;
    logic [7:0]  rx_byte;
    logic [7:0]  next_cmd;

`ifdef SD_BLOCK_CRC16_EN
    logic [15:0] crc_calc;
    logic [7:0]  crc_hi;
    logic        crc_fb;
    assign crc_fb = crc_calc[15] ^ MISO;
`endif

    // Even half-periods end on a rising SCK edge, odd ones on a falling edge.
    assign tick      = (div_cnt == DIV_LAST);
    assign rx_byte   = {rx_sr[6:0], MISO};
    assign MOSI      = tx_sr[7];
    assign dbg_state = state;

    // cnt holds the index of the command byte just finished.
    always_comb begin
        next_cmd = 8'hFF;
        case (cnt[2:0])
            3'd0:    next_cmd = arg[31:24];
            3'd1:    next_cmd = arg[23:16];
            3'd2:    next_cmd = arg[15:8];
            3'd3:    next_cmd = arg[7:0];
            default: next_cmd = 8'hFF;
        endcase
    end

    // rd_valid is a one-cycle strobe with no ready: the consumer must take rd_data
    // in that cycle; rd_data then holds until the next strobe (>= 16*CLK_DIV cycles).
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            CS       <= 1'b1;
            spi_clk  <= 1'b0;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= 8'h00;
            err_code <= 3'd0;
            div_cnt  <= 8'd0;
            half_cnt <= 4'd0;
            tx_sr    <= 8'hFF;
            rx_sr    <= 8'hFF;
            cnt      <= 16'd0;
            data_cnt <= 9'd0;
            arg      <= 32'd0;
            end_code <= 3'd0;
`ifdef SD_BLOCK_CRC16_EN
            crc_calc <= 16'd0;
            crc_hi   <= 8'd0;
`endif
        end else begin
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;
            rd_err   <= 1'b0;
            if (state == S_IDLE) begin
                CS       <= 1'b1;
                spi_clk  <= 1'b0;
                tx_sr    <= 8'hFF;
                div_cnt  <= 8'd0;
                half_cnt <= 4'd0;
                if (rd_req && init_done) begin
                    arg      <= sdhc ? rd_addr : {rd_addr[22:0], 9'b0};
                    busy     <= 1'b1;
                    err_code <= 3'd0;
                    end_code <= 3'd0;
                    cnt      <= 16'd0;
                    CS       <= 1'b0;
                    tx_sr    <= 8'h51;
                    state    <= S_CMD;
                end
            end else begin
                div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
                if (tick) begin
                    half_cnt <= half_cnt + 4'd1;
                    if (!half_cnt[0]) begin
                        spi_clk <= 1'b1;
                        rx_sr   <= rx_byte;
                        if (state == S_DATA) begin
`ifdef SD_BLOCK_CRC16_EN
                            crc_calc <= {crc_calc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif
                            if (half_cnt == 4'd14) begin
                                rd_data  <= rx_byte;
                                rd_valid <= 1'b1;
                            end
                        end
                    end else begin
                        spi_clk <= 1'b0;
                        if (half_cnt != 4'd15) begin
                            tx_sr <= {tx_sr[6:0], 1'b1};
                        end else begin
                            tx_sr <= 8'hFF;
                            case (state)
                                S_CMD: begin
                                    if (cnt == 16'd5) begin
                                        cnt   <= 16'd0;
                                        state <= S_R1_POLL;
                                    end else begin
                                        cnt   <= cnt + 16'd1;
                                        tx_sr <= next_cmd;
                                    end
                                end
                                S_R1_POLL: begin
                                    if (!rx_sr[7]) begin
                                        if (rx_sr == 8'h00) begin
                                            cnt   <= 16'd0;
                                            state <= S_TOKEN_WAIT;
                                        end else begin
                                            end_code <= 3'd2;
                                            CS       <= 1'b1;
                                            state    <= S_END;
                                        end
                                    end else if (cnt == R1_LAST) begin
                                        end_code <= 3'd1;
                                        CS       <= 1'b1;
                                        state    <= S_END;
                                    end else begin
                                        cnt <= cnt + 16'd1;
                                    end
                                end
                                S_TOKEN_WAIT: begin
                                    if (rx_sr == 8'hFE) begin
                                        data_cnt <= 9'd0;
`ifdef SD_BLOCK_CRC16_EN
                                        crc_calc <= 16'd0;
`endif
                                        state    <= S_DATA;
                                    end else if (rx_sr[7:4] == 4'h0) begin
                                        end_code <= 3'd4;
                                        CS       <= 1'b1;
                                        state    <= S_END;
                                    end else if (cnt == TOKEN_LAST) begin
                                        end_code <= 3'd3;
                                        CS       <= 1'b1;
                                        state    <= S_END;
                                    end else begin
                                        cnt <= cnt + 16'd1;
                                    end
                                end
                                S_DATA: begin
                                    if (data_cnt == 9'd511) begin
                                        cnt   <= 16'd0;
                                        state <= S_CRC;
                                    end else begin
                                        data_cnt <= data_cnt + 9'd1;
                                    end
                                end
                                S_CRC: begin
                                    if (cnt == 16'd0) begin
                                        cnt <= 16'd1;
`ifdef SD_BLOCK_CRC16_EN
                                        crc_hi <= rx_sr;
`endif
                                    end else begin
`ifdef SD_BLOCK_CRC16_EN
                                        end_code <= ({crc_hi, rx_sr} != crc_calc) ? 3'd5 : 3'd0;
`else
                                        end_code <= 3'd0;
`endif
                                        CS    <= 1'b1;
                                        state <= S_END;
                                    end
                                end
                                S_END: begin
                                    busy  <= 1'b0;
                                    state <= S_IDLE;
                                    if (end_code == 3'd0) begin
                                        rd_done <= 1'b1;
                                    end else begin
                                        rd_err   <= 1'b1;
                                        err_code <= end_code;
                                    end
                                end
                                default: state <= S_IDLE;
                            endcase
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_block_reader.sv
// Self-checking bench for sd_block_reader: SPI card model, data/end scoreboard queues, directed cases.
`timescale 1ns/1ps
module tb_sd_block_reader;

    localparam int CLK_DIV       = 2;
    localparam int R1_TIMEOUT    = 8;
    localparam int TOKEN_TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        init_done;
    logic        sdhc;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        busy;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_done;
    logic        rd_err;
    logic [2:0]  err_code;
    logic        CS;
    logic        MOSI;
    logic        spi_clk;
    logic        MISO;
    logic [2:0]  dbg_state;

    sd_block_reader #(
        .CLK_DIV      (CLK_DIV),
        .R1_TIMEOUT   (R1_TIMEOUT),
        .TOKEN_TIMEOUT(TOKEN_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .init_done(init_done),
        .sdhc     (sdhc),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_done  (rd_done),
        .rd_err   (rd_err),
        .err_code (err_code),
        .CS       (CS),
        .MOSI     (MOSI),
        .spi_clk  (spi_clk),
        .MISO     (MISO),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- card model ----------------
    logic [7:0] resp_q[$];
    logic [7:0] mosi_log[$];
    logic [7:0] card_out = 8'hFF;
    logic [7:0] card_in  = 8'hFF;
    int         card_bits = 0;
    logic       prev_cs  = 1'b1;
    logic       prev_sck = 1'b0;

    assign MISO = CS ? 1'b1 : card_out[7];

    function automatic logic [7:0] next_resp();
        if (resp_q.size() > 0) return resp_q.pop_front();
        return 8'hFF;
    endfunction

    always @(negedge clk) begin
        if (prev_cs && !CS) begin
            card_bits = 0;
            card_out  = next_resp();
        end else if (!CS) begin
            if (spi_clk && !prev_sck) begin
                card_in = {card_in[6:0], MOSI};
                card_bits++;
                if (card_bits == 8) begin
                    mosi_log.push_back(card_in);
                    card_bits = 0;
                end
            end else if (!spi_clk && prev_sck) begin
                if (card_bits == 0) card_out = next_resp();
                else card_out = {card_out[6:0], 1'b1};
            end
        end
        prev_cs  = CS;
        prev_sck = spi_clk;
    end

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q[$];
    logic [4:0] exp_end_q[$];   // {rd_done, rd_err, err_code}
    int valid_cnt = 0;
    int done_cnt  = 0;
    int cyc_done  = 0;
    int cyc_req   = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_valid_extra: got data 0x%0h with no byte expected", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end
            if (rd_done || rd_err) begin
                done_cnt++;
                cyc_done = cyc;
                if (exp_end_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL end_extra: got done=%0b err=%0b code=%0d with no end expected",
                             rd_done, rd_err, err_code);
                end else begin
                    check("end_status", {rd_done, rd_err, err_code}, exp_end_q.pop_front());
                end
                check("end_cs_busy", {CS, busy}, 2'b10);
                check("end_data_left", exp_q.size(), 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    task automatic push_ff(input int n);
        for (int i = 0; i < n; i++) resp_q.push_back(8'hFF);
    endtask

    task automatic push_block(input logic [7:0] seed, input bit bad_crc);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            b = 8'(i) ^ seed;
            resp_q.push_back(b);
            exp_q.push_back(b);
            c = crc_upd(c, b);
        end
        if (bad_crc) c = c ^ 16'h0001;
        resp_q.push_back(c[15:8]);
        resp_q.push_back(c[7:0]);
    endtask

    task automatic new_case();
        resp_q.delete();
        mosi_log.delete();
        push_ff(6);
    endtask

    task automatic issue(input logic s, input logic [31:0] a);
        @(negedge clk);
        sdhc    = s;
        rd_addr = a;
        rd_req  = 1'b1;
        cyc_req = cyc;
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string name);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (done_cnt == start) begin
            checks++;
            errors++;
            $display("FAIL %s: got no rd_done/rd_err within %0d cycles", name, budget);
        end
    endtask

    task automatic check_frame(input string name, input logic [31:0] a);
        check({name, "_cmd_crc"}, {mosi_log[0], mosi_log[5]}, 16'h51FF);
        check({name, "_arg"}, {mosi_log[1], mosi_log[2], mosi_log[3], mosi_log[4]}, a);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int t0;
        int diff;
        int v0;
        int n;
        rst       = 1'b1;
        init_done = 1'b0;
        sdhc      = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_cs", CS, 1'b1);
        check("rst_mosi", MOSI, 1'b1);
        check("rst_sck", spi_clk, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {rd_valid, rd_done, rd_err}, 3'b000);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_err_code", err_code, 3'd0);
        check("rst_state", dbg_state, 3'd0);
        rst = 1'b0;

        // request while not initialised is ignored
        new_case();
        issue(1'b1, 32'h10);
        repeat (100) @(negedge clk);
        check("noinit_busy", busy, 1'b0);
        check("noinit_cs", CS, 1'b1);
        check("noinit_bytes", mosi_log.size(), 0);
        check("noinit_end", done_cnt, 0);
        init_done = 1'b1;

        // full block, sdhc addressing, R1 after two 0xFF polls; second request while busy ignored
        new_case();
        resp_q.push_back(8'hFF);
        resp_q.push_back(8'hFF);
        resp_q.push_back(8'h00);
        resp_q.push_back(8'hFE);
        push_block(8'h00, 1'b0);
        exp_end_q.push_back(5'b10_000);
        issue(1'b1, 32'h0000_0010);
        t0 = cyc_req;
        repeat (2000) @(negedge clk);
        check("blk_busy", busy, 1'b1);
        issue(1'b1, 32'h0000_0055);
        wait_end(20000, "blk_end");
        diff = cyc_done - t0;
        checks++;
        if (diff < 16798 || diff > 16802) begin
            errors++;
            $display("FAIL blk_latency: got %0d cycles expected 16800 +-2", diff);
        end
        check_frame("blk", 32'h0000_0010);
        check("blk_bytes", mosi_log.size(), 524);
        check("blk_valid_cnt", valid_cnt, 512);
        repeat (200) @(negedge clk);
        check("blk_idle_busy", busy, 1'b0);
        check("blk_no_restart", mosi_log.size(), 524);

        // byte addressing, R1 = 0x04 -> err 2
        new_case();
        resp_q.push_back(8'h04);
        exp_end_q.push_back({2'b01, 3'd2});
        issue(1'b0, 32'd3);
        wait_end(1000, "r1err_end");
        check_frame("r1err", 32'h0000_0600);
        repeat (10) @(negedge clk);
        check("r1err_hold", err_code, 3'd2);

        // card silent -> err 1 after R1_TIMEOUT polls
        new_case();
        exp_end_q.push_back({2'b01, 3'd1});
        issue(1'b1, 32'h20);
        wait_end(2000, "r1to_end");
        check("r1to_bytes", mosi_log.size(), 6 + R1_TIMEOUT);

        // data error token 0x08 -> err 4
        new_case();
        resp_q.push_back(8'h00);
        resp_q.push_back(8'hFF);
        resp_q.push_back(8'h08);
        exp_end_q.push_back({2'b01, 3'd4});
        issue(1'b1, 32'h30);
        wait_end(2000, "tokerr_end");
        check("tokerr_bytes", mosi_log.size(), 9);

        // token never arrives -> err 3 after TOKEN_TIMEOUT polls
        new_case();
        resp_q.push_back(8'h00);
        exp_end_q.push_back({2'b01, 3'd3});
        issue(1'b1, 32'h40);
        wait_end(3000, "tokto_end");
        check("tokto_bytes", mosi_log.size(), 6 + 1 + TOKEN_TIMEOUT);

        // reset in the middle of DATA
        new_case();
        resp_q.push_back(8'h00);
        resp_q.push_back(8'hFE);
        push_block(8'h5A, 1'b0);
        exp_end_q.push_back(5'b10_000);
        issue(1'b1, 32'h50);
        v0 = valid_cnt;
        n = 0;
        while (valid_cnt < v0 + 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_progress", valid_cnt - v0, 10);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_cs_sck_busy", {CS, spi_clk, busy}, 3'b100);
        rst = 1'b0;
        exp_q.delete();
        exp_end_q.delete();
        resp_q.delete();
        repeat (100) @(negedge clk);
        check("rst_mid_quiet", valid_cnt - v0, 10);

        // full block with delayed token and ignorable junk bytes
        new_case();
        resp_q.push_back(8'hFF);
        resp_q.push_back(8'h00);
        resp_q.push_back(8'hFF);
        resp_q.push_back(8'hF0);
        resp_q.push_back(8'h3C);
        resp_q.push_back(8'hFE);
        push_block(8'hA5, 1'b0);
        exp_end_q.push_back(5'b10_000);
        v0 = valid_cnt;
        issue(1'b1, 32'hDEAD_BEEF);
        wait_end(20000, "blk2_end");
        check_frame("blk2", 32'hDEAD_BEEF);
        check("blk2_valid_cnt", valid_cnt - v0, 512);

`ifdef SD_BLOCK_CRC16_EN
        // corrupted CRC -> data still streamed, then err 5
        new_case();
        resp_q.push_back(8'h00);
        resp_q.push_back(8'hFE);
        push_block(8'h3C, 1'b1);
        exp_end_q.push_back({2'b01, 3'd5});
        v0 = valid_cnt;
        issue(1'b1, 32'h60);
        wait_end(20000, "crc_end");
        check("crc_valid_cnt", valid_cnt - v0, 512);
`endif

        repeat (20) @(negedge clk);
        check("final_end_q", exp_end_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
